// File: rtl/player_instr_encoder.sv
// player_instr_encoder: queues game events and turns them, or held direction buttons, into player instruction words
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   tick_10hz         - one-cycle strobe at the player movement sample point
//   btn_up/left/down/right - debounced, level-sensitive direction buttons
//   evt_valid/evt_op/evt_arg/evt_ready - event offer port, handshake on valid && ready
//   instruction       - {opcode, operand, 4'h0}; stat words last one cycle, move words last until a tick
//   fifo_level        - number of queued events
//   drop_count        - saturating count of rejected opcodes
module player_instr_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick_10hz,
  input  logic                          btn_up,
  input  logic                          btn_left,
  input  logic                          btn_down,
  input  logic                          btn_right,
  input  logic                          evt_valid,
  input  logic [3:0]                    evt_op,
  input  logic [7:0]                    evt_arg,
  output logic                          evt_ready,
  output logic [15:0]                   instruction,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, STAT, MOVE} state_t;
  state_t state, state_nx;
  logic [11:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count_nx;
  logic op_ok, push, drop, pop, decide, any_btn, empty;
  logic [7:0] dir;
  logic [15:0] instr_nx;
  always_comb begin
    op_ok    = (evt_op >= 4'h1 && evt_op <= 4'h4) || evt_op == 4'h6;
    empty    = fifo_level == '0;
    push     = evt_valid && evt_ready && op_ok;
    drop     = evt_valid && evt_ready && !op_ok;
    // A committed move only re-evaluates on a tick; every other state decides each cycle.
    decide   = state != MOVE || tick_10hz;
    pop      = decide && !empty;
    count_nx = fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    any_btn  = btn_up || btn_left || btn_down || btn_right;
    dir      = btn_up ? 8'd0 : btn_left ? 8'd1 : btn_down ? 8'd2 : 8'd3;
    state_nx = !decide ? state : !empty ? STAT : any_btn ? MOVE : IDLE;
    instr_nx = !decide ? instruction : !empty ? {mem[rd_ptr], 4'h0} :
               any_btn ? {4'h5, dir, 4'h0} : 16'h0000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instruction <= 16'h0000;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      drop_count  <= 8'd0;
      evt_ready   <= 1'b0;
    end else begin
      state       <= state_nx;
      instruction <= instr_nx;
      fifo_level  <= count_nx;
      evt_ready   <= count_nx != (AW+1)'(FIFO_DEPTH);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {evt_op, evt_arg};
  end
endmodule

// File: tb/tb_player_instr_encoder.sv
// tb_player_instr_encoder: directed self-checking bench for player_instr_encoder
module tb_player_instr_encoder;
  logic clk = 0, reset = 1, tick_10hz = 0;
  logic btn_up = 0, btn_left = 0, btn_down = 0, btn_right = 0;
  logic evt_valid = 0;
  logic [3:0] evt_op = 0;
  logic [7:0] evt_arg = 0;
  logic evt_ready;
  logic [15:0] instruction;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;
  int checks = 0, passes = 0;

  player_instr_encoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tick_10hz(tick_10hz),
    .btn_up(btn_up), .btn_left(btn_left), .btn_down(btn_down), .btn_right(btn_right),
    .evt_valid(evt_valid), .evt_op(evt_op), .evt_arg(evt_arg), .evt_ready(evt_ready),
    .instruction(instruction), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic offer(input logic [3:0] op, input logic [7:0] arg);
    evt_valid = 1;
    evt_op = op;
    evt_arg = arg;
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ready", evt_ready, 0);
    reset = 0;
    cyc();
    chk("ready_after_rst", evt_ready, 1);
    // single heal
    offer(4'h1, 8'h14);
    cyc();
    evt_valid = 0;
    chk("heal_level1", fifo_level, 1);
    chk("heal_pre", instruction, 16'h0000);
    cyc();
    chk("heal_word", instruction, 16'h1140);
    chk("heal_level0", fifo_level, 0);
    cyc();
    chk("heal_nop", instruction, 16'h0000);
    // back-to-back stats
    offer(4'h2, 8'h05);
    cyc();
    chk("b2b_idle", instruction, 16'h0000);
    offer(4'h3, 8'h02);
    cyc();
    chk("b2b_w1", instruction, 16'h2050);
    chk("b2b_level", fifo_level, 1);
    offer(4'h6, 8'h32);
    cyc();
    evt_valid = 0;
    chk("b2b_w2", instruction, 16'h3020);
    cyc();
    chk("b2b_w3", instruction, 16'h6320);
    cyc();
    chk("b2b_nop", instruction, 16'h0000);
    // move right held through a tick
    btn_right = 1;
    cyc();
    chk("mv_right", instruction, 16'h5030);
    for (int i = 0; i < 11; i++) begin
      cyc();
      chk("mv_hold", instruction, 16'h5030);
    end
    tick_10hz = 1;
    #2;
    chk("mv_tick_cycle", instruction, 16'h5030);
    cyc();
    tick_10hz = 0;
    btn_right = 0;
    chk("mv_reissue", instruction, 16'h5030);
    repeat (3) cyc();
    chk("mv_committed", instruction, 16'h5030);
    tick_10hz = 1;
    cyc();
    tick_10hz = 0;
    chk("mv_release_nop", instruction, 16'h0000);
    // priority: up beats down, queued event beats move
    btn_up = 1;
    btn_down = 1;
    cyc();
    chk("mv_up_wins", instruction, 16'h5000);
    offer(4'h1, 8'h0A);
    cyc();
    evt_valid = 0;
    chk("mv_evt_wait", instruction, 16'h5000);
    chk("mv_evt_level", fifo_level, 1);
    cyc();
    chk("mv_evt_still", instruction, 16'h5000);
    tick_10hz = 1;
    cyc();
    tick_10hz = 0;
    chk("mv_evt_first", instruction, 16'h10A0);
    chk("mv_evt_popped", fifo_level, 0);
    cyc();
    btn_up = 0;
    btn_down = 0;
    chk("mv_resume", instruction, 16'h5000);
    // fill the FIFO while moving
    for (int i = 1; i <= 4; i++) begin
      offer(4'h1, 8'(i));
      cyc();
    end
    chk("full_level", fifo_level, 4);
    chk("full_ready", evt_ready, 0);
    offer(4'h1, 8'h05);
    cyc();
    chk("full_ignored", fifo_level, 4);
    chk("full_move_held", instruction, 16'h5000);
    tick_10hz = 1;
    cyc();
    tick_10hz = 0;
    chk("full_pop_word", instruction, 16'h1010);
    chk("full_pop_level", fifo_level, 3);
    chk("full_ready_rise", evt_ready, 1);
    cyc();
    evt_valid = 0;
    chk("fifth_push_pop", instruction, 16'h1020);
    chk("fifth_level", fifo_level, 3);
    cyc();
    chk("drain3", instruction, 16'h1030);
    cyc();
    chk("drain4", instruction, 16'h1040);
    cyc();
    chk("drain5", instruction, 16'h1050);
    chk("drain_level", fifo_level, 0);
    cyc();
    chk("drain_nop", instruction, 16'h0000);
    // rejected opcodes
    offer(4'h5, 8'h33);
    cyc();
    offer(4'hF, 8'h44);
    cyc();
    evt_valid = 0;
    cyc();
    chk("drop_count", drop_count, 2);
    chk("drop_no_instr", instruction, 16'h0000);
    chk("drop_no_queue", fifo_level, 0);
    // reset mid-move discards queue
    btn_left = 1;
    cyc();
    chk("mv_left", instruction, 16'h5010);
    offer(4'h4, 8'h07);
    cyc();
    evt_valid = 0;
    chk("pre_rst_level", fifo_level, 1);
    reset = 1;
    cyc();
    chk("mid_rst_instr", instruction, 16'h0000);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_ready", evt_ready, 0);
    reset = 0;
    btn_left = 0;
    cyc();
    cyc();
    chk("post_rst_ready", evt_ready, 1);
    chk("post_rst_nop", instruction, 16'h0000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/player_instr_encoder.md
# player_instr_encoder

Produces the 16-bit instruction word consumed by the player-state block. Game events (heal, damage, ATK changes, HP set) arrive over a valid/ready port and are queued in a small FIFO; held direction buttons become move instructions. Each stat instruction appears for exactly one `clk` cycle, so the player block applies it once. Each move instruction is held until a `tick_10hz` strobe, so the player's 10 Hz movement logic samples it.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: event queue entries; power of two, at least 2.

Ports:
- `clk` in 1: system clock. Everything is single clock domain.
- `reset` in 1: synchronous, active-high.
- `tick_10hz` in 1: one-cycle strobe marking the player movement sample point.
- `btn_up`, `btn_left`, `btn_down`, `btn_right` in 1 each: level-sensitive, already debounced.
- `evt_valid` in 1: event offered.
- `evt_op` in 4: event opcode.
- `evt_arg` in 8: event operand.
- `evt_ready` out 1: event accepted on a cycle where `evt_valid && evt_ready`.
- `instruction` out 16: `{opcode[3:0], operand[7:0], 4'b0000}`.
- `fifo_level` out log2(FIFO_DEPTH)+1: number of queued events.
- `drop_count` out 8: count of rejected opcodes; saturates at 255.

## Operation

Opcode map:
- 0000 NOP
- 0001 heal
- 0010 damage
- 0011 ATK add
- 0100 ATK set
- 0101 move
- 0110 HP set

Event acceptance:
- Only 0001, 0010, 0011, 0100 and 0110 are enqueued.
- Any other `evt_op` (including 0101, 0000 and 0111–1111) is handshaken, not enqueued, and increments `drop_count` (saturating).
- `evt_ready = !full`, registered and driven from FIFO state only.
- A push and a pop in the same cycle are both honoured; the level is unchanged.

Direction codes, placed in operand[7:0]:
- up = 0, left = 1, down = 2, right = 3.
- If several buttons are held, the lowest code wins.

FSM states: IDLE, STAT, MOVE. `instruction` is registered and reflects the state entered.
- IDLE, FIFO non-empty → STAT: load the head as `{op, arg, 4'h0}` and pop. Queued events have priority over movement.
- IDLE, FIFO empty, any button held → MOVE: load `{4'b0101, dir, 4'h0}`. Direction is latched at entry.
- IDLE, otherwise: `instruction = 16'h0000`.
- STAT, next cycle: if FIFO non-empty, STAT again with the next entry (back-to-back, one word per cycle). Otherwise apply the IDLE rules for movement, or NOP.
- MOVE: hold the word unchanged until a cycle in which `tick_10hz` = 1. At that edge, apply the IDLE rules (FIFO first, then buttons, else NOP).
  - Releasing the buttons during MOVE does not abort; the move is committed.
  - Events arriving during MOVE queue and wait.

## Timing

Reset values: `instruction = 0`, state IDLE, FIFO empty, `fifo_level = 0`, `drop_count = 0`, `evt_ready = 0` while `reset` is high and 1 on the first cycle after.

Latency:
- An event accepted at edge N into an empty FIFO, with the FSM in IDLE, appears on `instruction` after edge N+1 and is valid for exactly one cycle.
- An event accepted while in MOVE waits for the tick plus one cycle.

Move hold:
- The move word is visible from the cycle after MOVE entry through the tick cycle inclusive, then changes at the next edge.
- If `tick_10hz` is high in the same cycle as IDLE→MOVE, that tick is not counted; the hold lasts until the next tick.

Edge cases:
- Full FIFO: `evt_ready` = 0 and `evt_valid` is ignored. `evt_ready` rises the cycle after a pop.
- `reset` mid-MOVE or mid-STAT: the next cycle shows the reset values; queued events are discarded.
- Pointers wrap modulo `FIFO_DEPTH`.

## Test plan

- Reset, then push op 0001 with arg 0x14 → `instruction = 0x1140` for exactly 1 cycle, then `0x0000`; `fifo_level` goes 1→0.
- Push 0010/0x05, 0011/0x02, 0110/0x32 back-to-back → `0x2050`, `0x3020`, `0x6320` on consecutive cycles, then `0x0000`.
- Hold `btn_right`, pulse `tick_10hz` 12 cycles later → `0x5030` held through the tick cycle, then re-issued as `0x5030` while the button is still held. Release the button → `0x0000` after the next tick.
- Hold `btn_up` and `btn_down` together → `0x5000` (up wins). Push heal 0x0A mid-MOVE → `0x10A0` appears the cycle after the tick, before any new move.
- Push 5 events with no tick while in MOVE (`FIFO_DEPTH` = 4) → `evt_ready` = 0 after the 4th; the 5th is not accepted until a pop.
- Push `evt_op` 0101 and then 1111 → no instruction change, `drop_count` = 2. Assert `reset` mid-move → `instruction = 0`, `fifo_level = 0`, `drop_count = 0`.
